// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by both the slave and the existing master.
// Holds the slave FSM state encoding, the address/byte widths and the
// acknowledge bit levels as they appear on sda.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    // Level of sda during the 9th clock: low means acknowledge.
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } i2cState;

endpackage

// File: rtl/i2c_line_sync.sv
// Input conditioning for the I2C bus lines.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   scl, sda       raw bus lines (asynchronous to clock)
//   sdaSync        synchronized sda level
//   sclRise        one-cycle pulse on a synchronized scl rising edge
//   sclFall        one-cycle pulse on a synchronized scl falling edge
//   start          one-cycle pulse: sda fell while scl was high
//   stop           one-cycle pulse: sda rose while scl was high
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic sdaSync,
    output logic sclRise,
    output logic sclFall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] sclPipe;
    logic [SYNC_STAGES-1:0] sdaPipe;
    logic                   sclSync;
    logic                   sclPrev;
    logic                   sdaPrev;

    // Both lines go through identical chains so their relative timing is
    // preserved; the extra Prev stage gives the edge detectors a history.
    // Everything resets to 1, the idle level of the bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclPipe <= '1;
            sdaPipe <= '1;
            sclPrev <= 1'b1;
            sdaPrev <= 1'b1;
        end else begin
            sclPipe <= {sclPipe[SYNC_STAGES-2:0], scl};
            sdaPipe <= {sdaPipe[SYNC_STAGES-2:0], sda};
            sclPrev <= sclSync;
            sdaPrev <= sdaSync;
        end
    end

    assign sclSync = sclPipe[SYNC_STAGES-1];
    assign sdaSync = sdaPipe[SYNC_STAGES-1];

    // START/STOP require scl high on both samples so an sda change that
    // coincides with an scl edge is never mistaken for a bus condition.
    assign sclRise = sclSync & ~sclPrev;
    assign sclFall = ~sclSync & sclPrev;
    assign start   = sclSync & sclPrev & sdaPrev & ~sdaSync;
    assign stop    = sclSync & sclPrev & ~sdaPrev & sdaSync;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave with a byte-stream interface (no clock stretching).
// Ports:
//   clock, reset        system clock (>= 8x scl), synchronous active-high reset
//   inData/inValid/inReady     bytes to return to the master on reads
//   outData/outValid/outReady  bytes received from the master on writes
//   selected            high while this slave is the addressed target
//   rdWr                R/W bit of the current addressed transfer (1 = read)
//   sda                 open-drain data line (driven low or released only)
//   scl                 bus clock from the master
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h10,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [I2C_BYTE_W-1:0] inData,
    input  logic                  inValid,
    output logic                  inReady,
    output logic [I2C_BYTE_W-1:0] outData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic                  selected,
    output logic                  rdWr,
    inout  wire                   sda,
    input  logic                  scl
);

    logic sdaSync, sclRise, sclFall, start, stop;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) lineSync (
        .clock   (clock),
        .reset   (reset),
        .scl     (scl),
        .sda     (sda),
        .sdaSync (sdaSync),
        .sclRise (sclRise),
        .sclFall (sclFall),
        .start   (start),
        .stop    (stop)
    );

    i2cState               state, nextState;
    logic [3:0]            bitCnt, nextBitCnt;
    logic [I2C_BYTE_W-1:0] shiftReg, nextShift;
    logic                  sdaLow, nextSdaLow;
    logic [I2C_BYTE_W-1:0] nextOutData;
    logic                  nextOutValid, nextSelected, nextRdWr;
    logic [I2C_BYTE_W-1:0] txBuf, nextTxBuf;
    logic                  txFull, nextTxFull;
    logic [I2C_BYTE_W-1:0] shiftedIn;
    logic [I2C_BYTE_W-1:0] txByte;

    assign sda       = sdaLow ? 1'b0 : 1'bz;
    assign shiftedIn = {shiftReg[I2C_BYTE_W-2:0], sdaSync};
    // An empty tx buffer reads as all ones, i.e. sda stays released.
    assign txByte    = txFull ? txBuf : 8'hFF;

    // State register and all datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            bitCnt   <= '0;
            shiftReg <= '0;
            sdaLow   <= 1'b0;
            outData  <= '0;
            outValid <= 1'b0;
            selected <= 1'b0;
            rdWr     <= 1'b0;
            txBuf    <= '0;
            txFull   <= 1'b0;
            inReady  <= 1'b0;
        end else begin
            state    <= nextState;
            bitCnt   <= nextBitCnt;
            shiftReg <= nextShift;
            sdaLow   <= nextSdaLow;
            outData  <= nextOutData;
            outValid <= nextOutValid;
            selected <= nextSelected;
            rdWr     <= nextRdWr;
            txBuf    <= nextTxBuf;
            txFull   <= nextTxFull;
            inReady  <= ~nextTxFull;
        end
    end

    // Next-state logic. Inside the ACK states bitCnt distinguishes the fall
    // that starts the 9th clock (8) from the fall that ends it (9). In
    // RD_DATA a fall with bitCnt 0 is the start of a byte and loads it.
    always_comb begin
        nextState    = state;
        nextBitCnt   = bitCnt;
        nextShift    = shiftReg;
        nextSdaLow   = sdaLow;
        nextOutData  = outData;
        nextOutValid = outValid;
        nextSelected = selected;
        nextRdWr     = rdWr;
        nextTxBuf    = txBuf;
        nextTxFull   = txFull;

        if (outValid && outReady) begin
            nextOutValid = 1'b0;
        end

        if (stop) begin
            nextState    = IDLE;
            nextBitCnt   = '0;
            nextSdaLow   = 1'b0;
            nextSelected = 1'b0;
        end else if (start) begin
            nextState    = ADDR;
            nextBitCnt   = '0;
            nextSdaLow   = 1'b0;
            nextSelected = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (sclRise) begin
                        nextShift  = shiftedIn;
                        nextBitCnt = bitCnt + 4'd1;
                        if (bitCnt == 4'd7) begin
                            if (shiftedIn[I2C_BYTE_W-1:1] == SLAVE_ADDR) begin
                                nextState  = ADDR_ACK;
                                nextBitCnt = 4'd8;
                            end else begin
                                nextState  = IGNORE;
                                nextBitCnt = '0;
                            end
                        end
                    end
                end
                ADDR_ACK, WR_ACK: begin
                    if (sclFall) begin
                        if (bitCnt == 4'd8) begin
                            nextSdaLow = ~ACK;
                            nextBitCnt = 4'd9;
                        end else begin
                            nextSdaLow = 1'b0;
                            nextBitCnt = '0;
                            nextState  = WR_DATA;
                            if (state == ADDR_ACK) begin
                                nextSelected = 1'b1;
                                nextRdWr     = shiftReg[0];
                                // A read starts on this same fall, so the
                                // first byte is loaded here.
                                if (shiftReg[0]) begin
                                    nextState  = RD_DATA;
                                    nextShift  = txByte;
                                    nextSdaLow = ~txByte[I2C_BYTE_W-1];
                                    nextTxFull = 1'b0;
                                end
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (sclRise) begin
                        nextShift  = shiftedIn;
                        nextBitCnt = bitCnt + 4'd1;
                        if (bitCnt == 4'd7) begin
                            if (!outValid) begin
                                nextOutData  = shiftedIn;
                                nextOutValid = 1'b1;
                                nextState    = WR_ACK;
                                nextBitCnt   = 4'd8;
                            end else begin
                                nextState    = IGNORE;
                                nextSelected = 1'b0;
                                nextBitCnt   = '0;
                            end
                        end
                    end
                end
                RD_DATA: begin
                    if (sclRise) begin
                        nextBitCnt = bitCnt + 4'd1;
                    end else if (sclFall) begin
                        if (bitCnt == 4'd0) begin
                            nextShift  = txByte;
                            nextSdaLow = ~txByte[I2C_BYTE_W-1];
                            nextTxFull = 1'b0;
                        end else if (bitCnt == 4'd8) begin
                            nextSdaLow = 1'b0;
                            nextBitCnt = '0;
                            nextState  = RD_ACK;
                        end else begin
                            nextShift  = {shiftReg[I2C_BYTE_W-2:0], 1'b0};
                            nextSdaLow = ~shiftReg[I2C_BYTE_W-2];
                        end
                    end
                end
                RD_ACK: begin
                    if (sclRise) begin
                        nextBitCnt = '0;
                        if (sdaSync == NACK) begin
                            nextState    = IGNORE;
                            nextSelected = 1'b0;
                        end else begin
                            nextState = RD_DATA;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        // Filling comes after the byte-start emptying so a byte offered in
        // the same cycle as an empty-buffer read is kept for the next one.
        if (inValid && inReady) begin
            nextTxBuf  = inData;
            nextTxFull = 1'b1;
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: a bit-banged I2C master drives scl and
// an open-drain sda, a table of write transactions plus directed sequences
// exercise the corner cases, and randomized transactions are compared
// against a transaction-level model of the slave.
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam logic [6:0] OWN = 7'h10;
    localparam int Q = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] inData = 8'h00;
    logic       inValid = 1'b0;
    logic       outReady = 1'b0;
    logic       scl = 1'b1;
    logic       mDrive = 1'b0;
    logic       inReady, outValid, selected, rdWr;
    logic [7:0] outData;
    wire        sdaBus;

    int errors = 0;
    int checks = 0;
    int hsCount = 0;
    int slaveLowCnt = 0;
    logic [7:0] rxQ[$];
    logic [7:0] expQ[$];

    assign sdaBus = mDrive ? 1'b0 : 1'bz;
    pullup (sdaBus);

    i2c_slave #(.SLAVE_ADDR(OWN), .SYNC_STAGES(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .inData   (inData),
        .inValid  (inValid),
        .inReady  (inReady),
        .outData  (outData),
        .outValid (outValid),
        .outReady (outReady),
        .selected (selected),
        .rdWr     (rdWr),
        .sda      (sdaBus),
        .scl      (scl)
    );

    always #5 clock = ~clock;

    // Record every consumer handshake and every cycle the slave pulls sda low.
    always @(posedge clock) begin
        if (!reset && outValid && outReady) begin
            hsCount++;
            rxQ.push_back(outData);
        end
        if (!mDrive && sdaBus === 1'b0) slaveLowCnt++;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitQ();
        repeat (Q) @(negedge clock);
    endtask

    task automatic clockBit(input logic tx, output logic rx);
        mDrive = ~tx;
        waitQ();
        scl = 1'b1;
        waitQ();
        rx = sdaBus;
        waitQ();
        scl = 1'b0;
        waitQ();
    endtask

    task automatic startCond();
        mDrive = 1'b0;
        waitQ();
        scl = 1'b1;
        waitQ();
        mDrive = 1'b1;
        waitQ();
        scl = 1'b0;
        waitQ();
    endtask

    task automatic stopCond();
        mDrive = 1'b1;
        waitQ();
        scl = 1'b1;
        waitQ();
        mDrive = 1'b0;
        waitQ();
        waitQ();
    endtask

    task automatic writeByte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) clockBit(b[i], dummy);
        clockBit(1'b1, ack);
    endtask

    task automatic readByte(input logic masterNack, output logic [7:0] b);
        logic dummy;
        for (int i = 7; i >= 0; i--) clockBit(1'b1, b[i]);
        clockBit(masterNack, dummy);
    endtask

    task automatic preload(input logic [7:0] v);
        int k = 0;
        while (!inReady && k < 20) begin
            @(negedge clock);
            k++;
        end
        checkOutput("preloadReady", inReady, 1'b1);
        inData  = v;
        inValid = 1'b1;
        @(negedge clock);
        inValid = 1'b0;
    endtask

    typedef struct {
        logic [7:0] addrByte;
        logic [7:0] dataByte;
        logic       readyLevel;
        logic       expAddrAck;
        logic       expDataAck;
        logic       expSelected;
        logic [7:0] expOutData;
        int         expHs;
    } vecT;

    vecT vecs[6];

    // One table row: S, address, (data if addressed), P, then drain.
    task automatic applyStimulus(input vecT v, input int idx);
        int   hsBefore;
        logic a, d;
        hsBefore    = hsCount;
        slaveLowCnt = 0;
        outReady    = v.readyLevel;
        startCond();
        writeByte(v.addrByte, a);
        checkOutput($sformatf("vec%0d addrAck", idx), a, v.expAddrAck);
        if (v.expAddrAck == ACK) begin
            writeByte(v.dataByte, d);
            checkOutput($sformatf("vec%0d dataAck", idx), d, v.expDataAck);
        end
        checkOutput($sformatf("vec%0d selected", idx), selected, v.expSelected);
        stopCond();
        checkOutput($sformatf("vec%0d selectedAfterP", idx), selected, 1'b0);
        checkOutput($sformatf("vec%0d outValidHeld", idx), outValid,
                    !v.readyLevel && (v.expAddrAck == ACK));
        checkOutput($sformatf("vec%0d slaveDrove", idx), slaveLowCnt != 0, v.expAddrAck == ACK);
        outReady = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput($sformatf("vec%0d handshakes", idx), hsCount - hsBefore, v.expHs);
        checkOutput($sformatf("vec%0d outData", idx), outData, v.expOutData);
        rxQ.delete();
    endtask

    initial begin
        logic       a, d;
        logic [7:0] b;
        logic       modelBufFull;
        logic [7:0] modelBuf;

        vecs[0] = '{8'h20, 8'h4A, 1'b1, ACK,  ACK,  1'b1, 8'h4A, 1};
        vecs[1] = '{8'h22, 8'h99, 1'b1, NACK, NACK, 1'b0, 8'h4A, 0};
        vecs[2] = '{8'h20, 8'h00, 1'b1, ACK,  ACK,  1'b1, 8'h00, 1};
        vecs[3] = '{8'h20, 8'hFF, 1'b1, ACK,  ACK,  1'b1, 8'hFF, 1};
        vecs[4] = '{8'h1E, 8'h12, 1'b1, NACK, NACK, 1'b0, 8'hFF, 0};
        vecs[5] = '{8'h20, 8'h81, 1'b0, ACK,  ACK,  1'b1, 8'h81, 1};

        // Reset values.
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("rstSda", sdaBus, 1'b1);
        checkOutput("rstOutValid", outValid, 1'b0);
        checkOutput("rstOutData", outData, 8'h00);
        checkOutput("rstInReady", inReady, 1'b0);
        checkOutput("rstSelected", selected, 1'b0);
        checkOutput("rstRdWr", rdWr, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("inReadyAfterRst", inReady, 1'b1);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

        // Overflow: second byte is dropped while the first is still pending.
        outReady = 1'b0;
        startCond();
        writeByte(8'h20, a);
        checkOutput("ovfAddrAck", a, ACK);
        writeByte(8'h01, d);
        checkOutput("ovfByte1Ack", d, ACK);
        writeByte(8'h02, d);
        checkOutput("ovfByte2Nack", d, NACK);
        checkOutput("ovfSelectedCleared", selected, 1'b0);
        stopCond();
        repeat (20) @(negedge clock);
        checkOutput("ovfOutDataHeld", outData, 8'h01);
        checkOutput("ovfOutValidHeld", outValid, 1'b1);
        outReady = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("ovfOutValidCleared", outValid, 1'b0);
        checkOutput("ovfHandshakes", rxQ.size(), 1);
        if (rxQ.size() > 0) checkOutput("ovfConsumed", rxQ[0], 8'h01);
        rxQ.delete();

        // Read of a preloaded byte, master NACKs.
        preload(8'hA5);
        checkOutput("inReadyFull", inReady, 1'b0);
        startCond();
        writeByte(8'h21, a);
        checkOutput("rdAddrAck", a, ACK);
        checkOutput("rdSelected", selected, 1'b1);
        checkOutput("rdRdWr", rdWr, 1'b1);
        readByte(NACK, b);
        checkOutput("rdByte", b, 8'hA5);
        stopCond();
        checkOutput("rdInReadyBack", inReady, 1'b1);
        checkOutput("rdStateIdle", 32'(dut.state), 32'(IDLE));

        // Empty read, then repeated START into a write.
        startCond();
        writeByte(8'h21, a);
        checkOutput("emptyAddrAck", a, ACK);
        readByte(NACK, b);
        checkOutput("emptyByte", b, 8'hFF);
        startCond();
        writeByte(8'h20, a);
        checkOutput("srAddrAck", a, ACK);
        writeByte(8'h33, d);
        checkOutput("srDataAck", d, ACK);
        stopCond();
        repeat (3) @(negedge clock);
        checkOutput("srOutData", outData, 8'h33);
        checkOutput("srRdWr", rdWr, 1'b0);
        checkOutput("srHandshakes", rxQ.size(), 1);
        rxQ.delete();
        outReady = 1'b0;

        // Randomized transactions against a transaction-level model.
        modelBufFull = 1'b0;
        modelBuf     = 8'h00;
        for (int t = 0; t < 16; t++) begin
            logic       own, rw, ready, pending, expAck;
            logic [6:0] addr7;
            int         n;
            own   = ($urandom_range(0, 3) != 0);
            rw    = 1'($urandom_range(0, 1));
            addr7 = OWN;
            if (!own) begin
                addr7 = 7'($urandom_range(0, 127));
                if (addr7 == OWN) addr7 = OWN ^ 7'h01;
            end
            if (rw && !modelBufFull && $urandom_range(0, 1) == 1) begin
                modelBuf     = 8'($urandom);
                modelBufFull = 1'b1;
                preload(modelBuf);
            end
            ready    = 1'($urandom_range(0, 1));
            outReady = ready;
            startCond();
            writeByte({addr7, rw}, a);
            checkOutput($sformatf("rnd%0d addrAck", t), a, own ? ACK : NACK);
            if (own && !rw) begin
                n       = $urandom_range(1, 3);
                pending = 1'b0;
                for (int j = 0; j < n; j++) begin
                    b      = 8'($urandom);
                    expAck = pending ? NACK : ACK;
                    writeByte(b, d);
                    checkOutput($sformatf("rnd%0d wrAck%0d", t, j), d, expAck);
                    if (expAck == NACK) break;
                    expQ.push_back(b);
                    if (!ready) pending = 1'b1;
                end
            end else if (own && rw) begin
                n = $urandom_range(1, 2);
                for (int j = 0; j < n; j++) begin
                    logic [7:0] expB;
                    expB         = modelBufFull ? modelBuf : 8'hFF;
                    modelBufFull = 1'b0;
                    readByte((j == n - 1) ? NACK : ACK, b);
                    checkOutput($sformatf("rnd%0d rdByte%0d", t, j), b, expB);
                end
            end
            stopCond();
            outReady = 1'b1;
            repeat (3) @(negedge clock);
            outReady = 1'b0;
            checkOutput($sformatf("rnd%0d rxCount", t), rxQ.size(), expQ.size());
            for (int j = 0; j < expQ.size() && j < rxQ.size(); j++)
                checkOutput($sformatf("rnd%0d rxByte%0d", t, j), rxQ[j], expQ[j]);
            rxQ.delete();
            expQ.delete();
        end

        // Reset in the middle of bit 3 of a 0x00 read byte.
        if (!modelBufFull) preload(8'h00);
        startCond();
        writeByte(8'h21, a);
        checkOutput("midRstAddrAck", a, ACK);
        clockBit(1'b1, d);
        clockBit(1'b1, d);
        mDrive = 1'b0;
        waitQ();
        scl = 1'b1;
        waitQ();
        checkOutput("midRstBitDriven", sdaBus, modelBufFull ? modelBuf[5] : 1'b0);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midRstSdaReleased", sdaBus, 1'b1);
        checkOutput("midRstOutValid", outValid, 1'b0);
        checkOutput("midRstOutData", outData, 8'h00);
        checkOutput("midRstInReady", inReady, 1'b0);
        checkOutput("midRstSelected", selected, 1'b0);
        checkOutput("midRstRdWr", rdWr, 1'b0);
        checkOutput("midRstState", 32'(dut.state), 32'(IDLE));
        reset = 1'b0;
        @(negedge clock);
        checkOutput("midRstInReadyBack", inReady, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h10, own 7-bit I2C address.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on scl/sda inputs (minimum 2).
REQ-003 clock  input  1  single system clock; clock SHALL be at least 8x the SCL frequency.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 inData  input  8  byte to transmit to the master on a read.
REQ-006 inValid  input  1  inData valid.
REQ-007 inReady  output  1  slave accepts inData this cycle.
REQ-008 outData  output  8  byte received from the master on a write.
REQ-009 outValid  output  1  outData valid.
REQ-010 outReady  input  1  consumer accepts outData this cycle.
REQ-011 selected  output  1  high while addressed (address ACK through STOP, repeated START or NACK).
REQ-012 rdWr  output  1  R/W bit of the current addressed transfer (1 = master reads).
REQ-013 sda  inout  1  open-drain data line: drive 0 or hi-Z only, never drive 1.
REQ-014 scl  input  1  bus clock from the master; no clock stretching.

Function
REQ-015 scl and sda SHALL pass through SYNC_STAGES flops; all edge, START and STOP decisions SHALL use the synchronized values only.
REQ-016 START = synchronized sda falling while scl high; STOP = sda rising while scl high.
REQ-017 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-018 START in any state SHALL go to ADDR with the bit counter cleared; repeated START SHALL behave the same way.
REQ-019 STOP in any state SHALL go to IDLE.
REQ-020 Bits SHALL be sampled on the scl rising edge, MSB first; sda SHALL change only after the scl falling edge.
REQ-021 ADDR: after 8 bits, on match with SLAVE_ADDR, the slave SHALL drive sda low from the following scl fall to the next scl fall (ACK), then set selected=1 and latch rdWr.
REQ-022 ADDR: on mismatch, the slave SHALL go to IGNORE and leave sda released.
REQ-023 WR_DATA: after 8 bits, if outValid=0 the byte SHALL load outData, set outValid=1 within 1 cycle of the 8th scl rise, and be ACKed.
REQ-024 WR_DATA: if outValid is still 1 (overflow), the byte SHALL be dropped, NACKed, and the state SHALL go to IGNORE.
REQ-025 outValid SHALL stay high with outData stable until outValid&&outReady; it SHALL then clear on the next cycle.
REQ-026 Read byte source: a 1-entry tx buffer. inReady=1 while the buffer is empty; the buffer loads on inValid&&inReady.
REQ-027 RD_DATA: at the scl fall that starts each byte, the buffer byte SHALL be shifted out and the buffer emptied; if the buffer is empty, 8'hFF SHALL be sent (sda released).
REQ-028 RD_ACK: on the 9th scl rise, sda low (master ACK) SHALL go to RD_DATA; sda high (NACK) SHALL go to IGNORE with sda released.
REQ-029 In IGNORE and IDLE, sda SHALL be released and only START/STOP are acted on.
REQ-030 When START and a data-bit edge occur in the same cycle, START SHALL take priority.
REQ-031 selected SHALL clear on STOP, START, or entry to IGNORE.
REQ-032 A pending outData SHALL survive STOP and START until it is consumed.

Reset
REQ-033 While reset is high, at a rising clock edge: state=IDLE; sda released; outValid=0; outData=0; inReady=0; selected=0; rdWr=0; tx buffer empty; bit counter=0; synchronizers loaded with 1.
REQ-034 inReady SHALL go to 1 on the first cycle after reset deasserts.
REQ-035 Reset mid-transfer SHALL release sda within 1 clock.

Structure
REQ-036 A shared package i2c_pkg SHALL hold the state encoding, I2C_ADDR_W=7, I2C_BYTE_W=8, and the ACK=0/NACK=1 constants, shared with the existing i2c master.
REQ-037 Sub-module i2c_line_sync SHALL contain the synchronizers plus the sclRise, sclFall, start and stop pulse detection.

Verification
REQ-038 Write: master model sends S, 0x20, 0x4A, P with outReady=1 -> both bytes ACKed, outData=0x4A, one outValid pulse, selected=1 then 0 after P.
REQ-039 Address mismatch: master sends S, 0x22 -> NACK on the 9th clock, sda never driven low, no outValid, selected stays 0.
REQ-040 Read: inData=0xA5 preloaded; master sends S, 0x21, reads 1 byte, NACKs, P -> sda bits 1,0,1,0,0,1,0,1, inReady returns high, state=IDLE.
REQ-041 Overflow: outReady=0; master writes 0x01, 0x02 -> 0x01 ACKed, 0x02 NACKed, outData holds 0x01 until outReady=1.
REQ-042 Empty read with repeated START: no inValid; master sends S, 0x21 -> byte read is 0xFF; then Sr, 0x20, 0x33, P -> outData=0x33, rdWr=0.
REQ-043 Reset mid-read: assert reset during bit 3 of a 0x00 read byte -> sda released by the next clock, all outputs at reset values.
